// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared stall-memory port.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_done, mem_err,
        output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_done, mem_err,
        input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch read-only, data read/write) arbiter in front of one stall memory.
// Define ARB_STATS_EN to add the saturating wait/conflict statistics outputs.
//
// state  | meaning
// IDLE   | no transaction held; arbitrate, D first unless I has been starved MAX_D_STREAK times
// BUSY_I | fetch read issued to memory, waiting for mem_done
// BUSY_D | data read/write issued to memory, waiting for mem_done
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4
`ifdef ARB_STATS_EN
    ,
    parameter int STAT_W       = 16
`endif
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_i_wait,
    output logic [STAT_W-1:0] stat_d_wait,
    output logic [STAT_W-1:0] stat_conflicts
`endif
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [STREAK_W-1:0] streak_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_rd_q;
    logic                mem_wr_q;

    logic streak_full;
    logic grant_i;
    logic grant_d;
    logic i_done;
    logic d_done;

    assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A starved fetch overrides the normal data-port priority exactly once.
                if (bus.d_req && !(bus.i_req && streak_full)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (grant_d) begin
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                mem_rd_q    <= !bus.d_we;
                mem_wr_q    <= bus.d_we;
            end else if (grant_i) begin
                mem_addr_q <= bus.i_addr;
                mem_rd_q   <= 1'b1;
                mem_wr_q   <= 1'b0;
            end else if ((state_q != IDLE) && bus.mem_done) begin
                mem_rd_q <= 1'b0;
                mem_wr_q <= 1'b0;
            end

            // Streak only moves while arbitrating; a busy period leaves it untouched.
            if (state_q == IDLE) begin
                if (grant_i || !bus.i_req) begin
                    streak_q <= '0;
                end else if (grant_d && !streak_full) begin
                    streak_q <= streak_q + 1'b1;
                end
            end
        end
    end

    assign i_done = (state_q == BUSY_I) && bus.mem_done;
    assign d_done = (state_q == BUSY_D) && bus.mem_done;

    assign bus.i_done  = i_done;
    assign bus.i_rdata = i_done ? bus.mem_rdata : '0;
    assign bus.i_err   = i_done && bus.mem_err;
    assign bus.d_done  = d_done;
    assign bus.d_rdata = d_done ? bus.mem_rdata : '0;
    assign bus.d_err   = d_done && bus.mem_err;

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] i_wait_q;
    logic [STAT_W-1:0] d_wait_q;
    logic [STAT_W-1:0] conflicts_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_wait_q    <= '0;
            d_wait_q    <= '0;
            conflicts_q <= '0;
        end else begin
            if (bus.i_req && (state_q != BUSY_I) && (i_wait_q != '1)) begin
                i_wait_q <= i_wait_q + 1'b1;
            end
            if (bus.d_req && (state_q != BUSY_D) && (d_wait_q != '1)) begin
                d_wait_q <= d_wait_q + 1'b1;
            end
            if ((state_q == IDLE) && bus.i_req && bus.d_req && (conflicts_q != '1)) begin
                conflicts_q <= conflicts_q + 1'b1;
            end
        end
    end

    assign stat_i_wait    = i_wait_q;
    assign stat_d_wait    = d_wait_q;
    assign stat_conflicts = conflicts_q;
`endif

endmodule
